// File: rtl/multimode_ff_pkg.sv
// Shared types and next-state rule for the multimode flip-flop bank.
// One function defines every personality so cells and models agree.
package multimode_ff_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'd0,
        MODE_T  = 2'd1,
        MODE_JK = 2'd2,
        MODE_SR = 2'd3
    } ff_mode_t;

    // SR with a=b=1 is the illegal case: set_dom picks set, otherwise hold.
    function automatic logic ff_next(
        input ff_mode_t mode,
        input logic     a,
        input logic     b,
        input logic     q,
        input logic     set_dom
    );
        logic nq;
        nq = q;
        case (mode)
            MODE_D:  nq = a;
            MODE_T:  nq = q ^ a;
            MODE_JK: nq = (a & ~q) | (~b & q);
            MODE_SR: begin
                if (a && b)  nq = set_dom ? 1'b1 : q;
                else if (a)  nq = 1'b1;
                else if (b)  nq = 1'b0;
                else         nq = q;
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/multimode_ff_bank_ff_cell.sv
// One storage bit of the bank: rst > load > en > hold, plus a change pulse
// and a combinational flag for the illegal SR input on this bit.
module ff_cell
    import multimode_ff_pkg::*;
#(
    parameter bit SET_DOM = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  ff_mode_t mode,
    input  logic     a,
    input  logic     b,
    input  logic     load,
    input  logic     load_val,
    input  logic     rst_val,
    output logic     q,
    output logic     changed,
    output logic     illegal
);

    logic r_q;
    logic r_changed;
    logic w_next;

    always_comb begin
        w_next = r_q;
        if (rst)       w_next = rst_val;
        else if (load) w_next = load_val;
        else if (en)   w_next = ff_next(mode, a, b, r_q, SET_DOM);
    end

    always_ff @(posedge clk) begin
        r_q       <= w_next;
        r_changed <= rst ? 1'b0 : (w_next ^ r_q);
    end

    // Reset is excluded in the top, which owns the sticky error state.
    assign illegal = en & ~load & (mode == MODE_SR) & a & b;
    assign q       = r_q;
    assign changed = r_changed;

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH cells sharing one runtime-selected personality (D/T/JK/SR),
// with sticky recording of illegal SR inputs.
module multimode_ff_bank
    import multimode_ff_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}},
    parameter bit               SR_SET_DOMINANT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err,
    output logic [WIDTH-1:0] sr_err_bits
);

    ff_mode_t         w_mode;
    logic [WIDTH-1:0] w_illegal;
    logic [WIDTH-1:0] r_err_bits;
    logic             r_err;

    assign w_mode = ff_mode_t'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .SET_DOM (SR_SET_DOMINANT)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .mode     (w_mode),
            .a        (a[i]),
            .b        (b[i]),
            .load     (load),
            .load_val (load_val[i]),
            .rst_val  (RESET_VAL[i]),
            .q        (q[i]),
            .changed  (changed[i]),
            .illegal  (w_illegal[i])
        );
    end

    // A new error beats err_clr: flags end holding only the new offenders.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_bits <= '0;
            r_err      <= 1'b0;
        end else if (|w_illegal) begin
            r_err_bits <= (err_clr ? '0 : r_err_bits) | w_illegal;
            r_err      <= 1'b1;
        end else if (err_clr) begin
            r_err_bits <= '0;
            r_err      <= 1'b0;
        end
    end

    assign q_n         = ~q;
    assign sr_err      = r_err;
    assign sr_err_bits = r_err_bits;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed-vector bench for multimode_ff_bank: hold-dominant instance with
// RESET_VAL=A5 plus a set-dominant twin fed the same stimulus.
module tb_multimode_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       load;
    logic [7:0] load_val;
    logic       err_clr;

    logic [7:0] q, q_n, changed, sr_err_bits;
    logic       sr_err;
    logic [7:0] sd_q, sd_q_n, sd_changed, sd_err_bits;
    logic       sd_err;

    int n_vec = 0;
    int n_err = 0;

    multimode_ff_bank #(
        .WIDTH(8), .RESET_VAL(8'hA5), .SR_SET_DOMINANT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .q(q), .q_n(q_n), .changed(changed),
        .sr_err(sr_err), .sr_err_bits(sr_err_bits)
    );

    multimode_ff_bank #(
        .WIDTH(8), .RESET_VAL(8'hA5), .SR_SET_DOMINANT(1'b1)
    ) dut_sd (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .q(sd_q), .q_n(sd_q_n), .changed(sd_changed),
        .sr_err(sd_err), .sr_err_bits(sd_err_bits)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; a = '0; b = '0;
        load = 1'b0; load_val = '0; err_clr = 1'b0;

        // reset
        step();
        check("rst_q", q, 8'hA5);
        check("rst_qn", q_n, 8'h5A);
        check("rst_changed", changed, 8'h00);
        check("rst_err", sr_err, 1'b0);
        check("rst_err_bits", sr_err_bits, 8'h00);
        check("rst_sd_q", sd_q, 8'hA5);
        rst = 1'b0;

        // D mode, then en=0 hold
        mode = 2'd0; en = 1'b1; a = 8'h3C;
        step();
        check("d_q", q, 8'h3C);
        check("d_changed", changed, 8'h99);
        en = 1'b0; a = 8'hFF;
        step();
        check("hold_q", q, 8'h3C);
        check("hold_changed", changed, 8'h00);

        // T mode toggling
        do_load(8'h00);
        check("load00_changed", changed, 8'h3C);
        mode = 2'd1; en = 1'b1; a = 8'h0F;
        step(); check("t1_q", q, 8'h0F); check("t1_changed", changed, 8'h0F);
        step(); check("t2_q", q, 8'h00); check("t2_changed", changed, 8'h0F);
        step(); check("t3_q", q, 8'h0F); check("t3_changed", changed, 8'h0F);

        // JK mode
        do_load(8'hF0);
        check("loadF0_changed", changed, 8'hFF);
        mode = 2'd2; a = 8'hCC; b = 8'hAA;
        step();
        check("jk_q", q, 8'h5C);
        check("jk_qn", q_n, 8'hA3);
        check("jk_changed", changed, 8'hAC);

        // SR mode with one illegal bit
        do_load(8'h00);
        mode = 2'd3; a = 8'h03; b = 8'h01;
        step();
        check("sr_q", q, 8'h02);
        check("sr_err", sr_err, 1'b1);
        check("sr_err_bits", sr_err_bits, 8'h01);
        check("sr_sd_q", sd_q, 8'h03);
        check("sr_sd_err", sd_err, 1'b1);
        err_clr = 1'b1; a = 8'h00; b = 8'h00;
        step();
        check("clr_err", sr_err, 1'b0);
        check("clr_err_bits", sr_err_bits, 8'h00);
        check("clr_q", q, 8'h02);

        // sticky accumulation, then err_clr colliding with a new error
        err_clr = 1'b0; a = 8'h81; b = 8'h81;
        step();
        check("err81_bits", sr_err_bits, 8'h81);
        check("err81_q", q, 8'h02);
        check("err81_sd_q", sd_q, 8'h83);
        err_clr = 1'b1; a = 8'h04; b = 8'h04;
        step();
        check("clr_new_err", sr_err, 1'b1);
        check("clr_new_bits", sr_err_bits, 8'h04);
        check("clr_new_sd_q", sd_q, 8'h87);
        err_clr = 1'b0; a = 8'h00; b = 8'h00;
        step();
        check("sticky_bits", sr_err_bits, 8'h04);
        check("sticky_err", sr_err, 1'b1);

        // en=0 records no error
        err_clr = 1'b1;
        step();
        err_clr = 1'b0; en = 1'b0; a = 8'hFF; b = 8'hFF;
        step();
        check("en0_err", sr_err, 1'b0);
        check("en0_q", q, 8'h02);

        // load beats SR illegal inputs, no error recorded
        en = 1'b1; load = 1'b1; load_val = 8'h77;
        step();
        check("load_q", q, 8'h77);
        check("load_changed", changed, 8'h75);
        check("load_err", sr_err, 1'b0);
        check("load_sd_q", sd_q, 8'h77);

        // rst beats load
        rst = 1'b1;
        step();
        check("rst_load_q", q, 8'hA5);
        check("rst_load_changed", changed, 8'h00);
        rst = 1'b0; en = 1'b0; a = '0; b = '0;

        // load equal to current q gives no change pulse
        load_val = 8'hA5;
        step();
        load = 1'b0;
        check("load_same_q", q, 8'hA5);
        check("load_same_changed", changed, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
